// File: rtl/crypto_seq_pkg.sv
// Shared definitions for the 4-isogeny command sequencer.
//   - wrapper instruction codes and command field widths
//   - sequencer FSM state encoding
//   - wrapper register map
//   - the fixed 9-op 4-isogeny program
package crypto_seq_pkg;

  localparam int         FIELD_W = 40;
  localparam logic [40:0] FIELD_P = 41'd574448099311;

  localparam int INS_W  = 3;
  localparam int ADDR_W = 7;

  typedef enum logic [INS_W-1:0] {
    INS_IDLE = 3'd0,
    INS_LOAD = 3'd1,
    INS_COPY = 3'd2,
    INS_ADD  = 3'd3,
    INS_SUB  = 3'd4,
    INS_MUL  = 3'd5
  } ins_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_GAP   = 3'd3,
    S_READ  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } seq_state_e;

  localparam logic [ADDR_W-1:0] A_X  = 7'd0;
  localparam logic [ADDR_W-1:0] A_Z  = 7'd1;
  localparam logic [ADDR_W-1:0] A_A  = 7'd2;
  localparam logic [ADDR_W-1:0] A_C  = 7'd3;
  localparam logic [ADDR_W-1:0] A_K1 = 7'd4;
  localparam logic [ADDR_W-1:0] A_K2 = 7'd5;
  localparam logic [ADDR_W-1:0] A_K3 = 7'd6;

  // 24-bit wrapper command word: {INS, rd_addr_1, rd_addr_2, wr_addr}
  typedef struct packed {
    ins_e              ins;
    logic [ADDR_W-1:0] rd1;
    logic [ADDR_W-1:0] rd2;
    logic [ADDR_W-1:0] wr;
  } cmd_t;

  localparam int PROG_LEN = 9;

  // K2=X-Z, K3=X+Z, C=4Z^4, K1=4Z^2, A=4X^4. Reg 4 is scratch for Z^2 before it becomes K1.
  localparam cmd_t PROG [0:PROG_LEN-1] = '{
    '{INS_SUB, A_X,  A_Z,  A_K2},
    '{INS_ADD, A_X,  A_Z,  A_K3},
    '{INS_MUL, A_Z,  A_Z,  A_K1},
    '{INS_ADD, A_K1, A_K1, A_K1},
    '{INS_MUL, A_K1, A_K1, A_C },
    '{INS_ADD, A_K1, A_K1, A_K1},
    '{INS_MUL, A_X,  A_X,  A_A },
    '{INS_ADD, A_A,  A_A,  A_A },
    '{INS_MUL, A_A,  A_A,  A_A }
  };

endpackage

// File: rtl/mod_reduce_40.sv
// Combinational canonicalisation of a redundant readback pair.
//   a, b : redundant halves from the wrapper (each < 2^W)
//   r    : (a + b) mod P, in [0, P)
// The sum fits in W+1 bits and is < 4P, so subtracting the largest of
// 3P/2P/P/0 that does not exceed it gives the canonical value.
module mod_reduce_40
  import crypto_seq_pkg::*;
#(
  parameter int       W = FIELD_W,
  parameter logic [W:0] P = FIELD_P
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  logic [W+1:0] s, p1, p2, p3, d;

  always_comb begin
    s  = {2'b00, a} + {2'b00, b};
    p1 = {1'b0, P};
    p2 = p1 << 1;
    p3 = p2 + p1;
    if (s >= p3)      d = s - p3;
    else if (s >= p2) d = s - p2;
    else if (s >= p1) d = s - p1;
    else              d = s;
    r = W'(d);
  end

endmodule

// File: rtl/iso4_cmd_sequencer_40.sv
// 4-isogeny command initiator for cryptoprocessor_wrapper_40.
// Loads (x,z), runs the fixed program, reads back A,C,K1,K2,K3 and
// stores each canonically reduced.
//   clk, rst (sync, active high), start (rising edge accepted in IDLE)
//   x_in, z_in       : point, sampled with start
//   busy, done       : run status; done is a 1-cycle pulse
//   a_out..k3_out    : results, held until overwritten by the next run
//   get_output, data_en, ins_in, command_in, din_1, din_2 : to wrapper
//   dout_1, dout_2   : redundant readback, valid 1 cycle after request
// Optional build macro SEQ_SINGLE_STEP_EN adds input `step`: each
// command is then issued only in the cycle after step was high.
module iso4_cmd_sequencer_40
  import crypto_seq_pkg::*;
#(
  parameter int         W        = FIELD_W,
  parameter logic [W:0] P        = FIELD_P,
  parameter int         READ_GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic         step,
`endif
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] z_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] a_out,
  output logic [W-1:0] c_out,
  output logic [W-1:0] k1_out,
  output logic [W-1:0] k2_out,
  output logic [W-1:0] k3_out,
  output logic         get_output,
  output logic         data_en,
  output logic         ins_in,
  output logic [23:0]  command_in,
  output logic [W-1:0] din_1,
  output logic [W-1:0] din_2,
  input  logic [W-1:0] dout_1,
  input  logic [W-1:0] dout_2
);

  localparam logic [7:0] GAP_LAST = (READ_GAP > 0) ? 8'(READ_GAP - 1) : 8'd0;

  seq_state_e          state;
  logic [7:0]          idx;
  logic                start_q;
  logic [W-1:0]        x_r, z_r;
  logic [2:0]          req_sel, cap_sel;
  logic                cap_vld;
  logic [4:0][W-1:0]   res;
  logic [W-1:0]        red;
  logic                adv;

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  mod_reduce_40 #(.W(W), .P(P)) u_red (.a(dout_1), .b(dout_2), .r(red));

  assign din_2  = '0;
  assign a_out  = res[0];
  assign c_out  = res[1];
  assign k1_out = res[2];
  assign k2_out = res[3];
  assign k3_out = res[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      start_q    <= 1'b0;
      x_r        <= '0;
      z_r        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      get_output <= 1'b0;
      data_en    <= 1'b0;
      ins_in     <= 1'b0;
      command_in <= '0;
      din_1      <= '0;
      req_sel    <= '0;
      cap_sel    <= '0;
      cap_vld    <= 1'b0;
      res        <= '0;
    end else begin
      start_q    <= start;
      // idle bus unless a state below issues something this cycle
      get_output <= 1'b0;
      data_en    <= 1'b0;
      ins_in     <= 1'b0;
      command_in <= '0;
      din_1      <= '0;
      done       <= 1'b0;

      // readback pipe: request visible now -> data valid next cycle
      cap_vld <= get_output;
      cap_sel <= req_sel;
      if (cap_vld) res[cap_sel] <= red;

      case (state)
        S_IDLE: begin
          // done still high means we left DONE this edge; a start now is ignored
          if (start && !start_q && !done) begin
            x_r   <= x_in;
            z_r   <= z_in;
            busy  <= 1'b1;
            state <= S_LOAD;
`ifdef SEQ_SINGLE_STEP_EN
            idx   <= 8'd0;
`else
            // first load goes out straight away so X lands in cycle 1
            ins_in     <= 1'b1;
            data_en    <= 1'b1;
            command_in <= {INS_LOAD, 7'd0, 7'd0, A_X};
            din_1      <= x_in;
            idx        <= 8'd1;
`endif
          end
        end
        S_LOAD: if (adv) begin
          ins_in     <= 1'b1;
          data_en    <= 1'b1;
          command_in <= {INS_LOAD, 7'd0, 7'd0, (idx == 8'd0) ? A_X : A_Z};
          din_1      <= (idx == 8'd0) ? x_r : z_r;
          if (idx == 8'd1) begin
            idx   <= 8'd0;
            state <= S_EXEC;
          end else idx <= idx + 8'd1;
        end
        S_EXEC: if (adv) begin
          ins_in     <= 1'b1;
          command_in <= PROG[idx[3:0]];
          if (idx == 8'(PROG_LEN - 1)) begin
            idx   <= 8'd0;
            state <= (READ_GAP > 0) ? S_GAP : S_READ;
          end else idx <= idx + 8'd1;
        end
        S_GAP: if (adv) begin
          if (idx == GAP_LAST) begin
            idx   <= 8'd0;
            state <= S_READ;
          end else idx <= idx + 8'd1;
        end
        S_READ: if (adv) begin
          get_output <= 1'b1;
          command_in <= {INS_IDLE, A_A + idx[6:0], 7'd0, 7'd0};
          req_sel    <= idx[2:0];
          if (idx == 8'd4) begin
            idx   <= 8'd0;
            state <= S_DRAIN;
          end else idx <= idx + 8'd1;
        end
        // last request's data arrives during the cycle after this one
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iso4_cmd_sequencer_40.sv
module tb_iso4_cmd_sequencer_40;
  localparam int         W   = 40;
  localparam logic [W:0] P   = 41'd574448099311;
  localparam int         GAP = 0;
  localparam int         D   = 18 + GAP;
  localparam logic [127:0] PW = 128'(P);

  typedef logic [4:0][W-1:0] res_t;
  typedef struct packed {
    logic de; logic ii; logic go; logic [23:0] cmd; logic [W-1:0] din;
  } tr_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] x_in, z_in;
`ifdef SEQ_SINGLE_STEP_EN
  logic step;
`endif
  logic busy, done, get_output, data_en, ins_in;
  logic [W-1:0] a_out, c_out, k1_out, k2_out, k3_out, din_1, din_2;
  logic [23:0] command_in;
  logic [W-1:0] dout_1, dout_2;

  iso4_cmd_sequencer_40 #(.READ_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .x_in(x_in), .z_in(z_in), .busy(busy), .done(done),
    .a_out(a_out), .c_out(c_out), .k1_out(k1_out), .k2_out(k2_out), .k3_out(k3_out),
    .get_output(get_output), .data_en(data_en), .ins_in(ins_in),
    .command_in(command_in), .din_1(din_1), .din_2(din_2),
    .dout_1(dout_1), .dout_2(dout_2));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- field arithmetic ----------------
  function automatic logic [W-1:0] addm(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'((128'(a) % PW + 128'(b) % PW) % PW);
  endfunction
  function automatic logic [W-1:0] subm(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'((128'(a) % PW + PW - 128'(b) % PW) % PW);
  endfunction
  function automatic logic [W-1:0] mulm(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(((128'(a) % PW) * (128'(b) % PW)) % PW);
  endfunction

  // closed-form 4-isogeny results: {K3, K2, K1, C, A} packed, index 0 = A
  function automatic res_t iso4(input logic [W-1:0] x, input logic [W-1:0] z);
    res_t r;
    logic [W-1:0] x2, z2;
    x2 = mulm(x, x);
    z2 = mulm(z, z);
    r[0] = mulm(40'd4, mulm(x2, x2));
    r[1] = mulm(40'd4, mulm(z2, z2));
    r[2] = mulm(40'd4, z2);
    r[3] = subm(x, z);
    r[4] = addm(x, z);
    return r;
  endfunction

  // expected k-th bus transaction of a run
  function automatic tr_t exp_tr(input int k, input logic [W-1:0] x, input logic [W-1:0] z);
    tr_t t;
    t = '0;
    if (k < 2) begin
      t.de = 1'b1; t.ii = 1'b1;
      t.cmd = {3'd1, 7'd0, 7'd0, 7'(k)};
      t.din = (k == 0) ? x : z;
    end else if (k < 11) begin
      t.ii = 1'b1;
      case (k)
        2:  t.cmd = {3'd4, 7'd0, 7'd1, 7'd5};
        3:  t.cmd = {3'd3, 7'd0, 7'd1, 7'd6};
        4:  t.cmd = {3'd5, 7'd1, 7'd1, 7'd4};
        5:  t.cmd = {3'd3, 7'd4, 7'd4, 7'd4};
        6:  t.cmd = {3'd5, 7'd4, 7'd4, 7'd3};
        7:  t.cmd = {3'd3, 7'd4, 7'd4, 7'd4};
        8:  t.cmd = {3'd5, 7'd0, 7'd0, 7'd2};
        9:  t.cmd = {3'd3, 7'd2, 7'd2, 7'd2};
        default: t.cmd = {3'd5, 7'd2, 7'd2, 7'd2};
      endcase
    end else begin
      t.go = 1'b1;
      t.cmd = {3'd0, 7'(k - 9), 7'd0, 7'd0};
    end
    return t;
  endfunction

  function automatic int exp_cyc(input int k);
    return (k < 11) ? k + 1 : k + 1 + GAP;
  endfunction

  // ---------------- wrapper stub ----------------
  logic [W-1:0] regs [0:127];
  logic         stub_en = 1'b0;
  logic [W-1:0] stub1 [0:6];
  logic [W-1:0] stub2 [0:6];
  int           rdn = 0;

  always @(posedge clk) begin : wrap
    logic [2:0] ins;
    logic [6:0] r1, r2, wa;
    logic [41:0] sm;
    {ins, r1, r2, wa} = command_in;
    if (ins_in && data_en && ins == 3'd1) regs[wa] <= addm(din_1, din_2);
    else if (ins_in && ins == 3'd3) regs[wa] <= addm(regs[r1], regs[r2]);
    else if (ins_in && ins == 3'd4) regs[wa] <= subm(regs[r1], regs[r2]);
    else if (ins_in && ins == 3'd5) regs[wa] <= mulm(regs[r1], regs[r2]);
    if (get_output) begin
      if (stub_en) begin
        dout_1 <= stub1[r1];
        dout_2 <= stub2[r1];
      end else begin
        // redundant form: value + t*P split across both halves
        sm = 42'(regs[r1]) + 42'(rdn % 4) * 42'(P);
        while (sm > 42'd2199023255550) sm = sm - 42'(P);
        dout_1 <= W'(sm >> 1);
        dout_2 <= W'(sm - (sm >> 1));
        rdn++;
      end
    end else begin
      dout_1 <= W'({$urandom(), $urandom()});
      dout_2 <= W'({$urandom(), $urandom()});
    end
  end

  // ---------------- model + compare ----------------
  int   rc = 0, ncmd = 0;
  logic start_prev = 1'b0;
  logic [W-1:0] rx = '0, rz = '0;
  res_t res_now = '0, res_run = '0, stub_exp;

  always @(negedge clk) begin : cmp
    tr_t  act, ex;
    logic at_done, active;
    res_t rexp;
    act = {data_en, ins_in, get_output, command_in, din_1};
`ifdef SEQ_SINGLE_STEP_EN
    at_done = (rc > 0) && done;
    if (rc > 2000) begin
      chk("step_run_timeout", rc, 0);
      rc = 0;
    end
`else
    at_done = (rc == D);
`endif
    chk("busy", busy, (rc > 0) && !at_done);
    chk("done", done, at_done);
    chk("din_2", din_2, 0);
    chk("get_and_load", get_output & data_en, 0);
    active = data_en | ins_in | get_output;
    if (active) begin
      if (ncmd < 16) begin
        ex = exp_tr(ncmd, rx, rz);
        chk($sformatf("cmd%0d", ncmd), act, ex);
`ifndef SEQ_SINGLE_STEP_EN
        chk($sformatf("cmd%0d_cycle", ncmd), rc, exp_cyc(ncmd));
`endif
      end else chk("cmd_extra", act, 0);
      ncmd++;
    end else begin
      chk("idle_cmd", command_in, 0);
      chk("idle_din", din_1, 0);
    end
    if (at_done || rc == 0) begin
      rexp = at_done ? res_run : res_now;
      chk("a_out", a_out, rexp[0]);
      chk("c_out", c_out, rexp[1]);
      chk("k1_out", k1_out, rexp[2]);
      chk("k2_out", k2_out, rexp[3]);
      chk("k3_out", k3_out, rexp[4]);
      if (at_done) begin
        chk("ncmd_at_done", ncmd, 16);
        res_now = res_run;
      end
    end
    // advance model to what the coming edge does
    if (rst) begin
      rc = 0; ncmd = 0; res_now = '0;
    end else if (rc == 0) begin
      if (start && !start_prev) begin
        rc = 1; ncmd = 0; rx = x_in; rz = z_in;
        res_run = stub_en ? stub_exp : iso4(x_in, z_in);
      end
    end else if (at_done) rc = 0;
    else rc++;
    start_prev = rst ? 1'b0 : start;
  end

`ifdef SEQ_SINGLE_STEP_EN
  initial begin
    int c = 0;
    step = 1'b0;
    forever begin
      @(posedge clk); #1;
      step = (c % 4 == 3);
      c++;
    end
  end
  localparam int BUDGET = 400;
`else
  localparam int BUDGET = 60;
`endif

  // ---------------- stimulus ----------------
  task automatic wait_done();
    int n = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done after %0d cycles, required within %0d", n, BUDGET);
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] z);
    @(posedge clk); #1;
    x_in = x; z_in = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] X0 = 40'd321876672963;
  localparam logic [W-1:0] Z0 = 40'd127852763491;

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; x_in = '0; z_in = '0;
    stub1[0] = '0; stub2[0] = '0; stub1[1] = '0; stub2[1] = '0;
    stub1[2] = W'(P) - 40'd1;   stub2[2] = W'(P) - 40'd1;
    stub1[3] = 40'hFF_FFFF_FFFF; stub2[3] = 40'hFF_FFFF_FFFF;
    stub1[4] = '0;              stub2[4] = '0;
    stub1[5] = W'(P);           stub2[5] = '0;
    stub1[6] = W'(P);           stub2[6] = W'(P) - 40'd1;
    stub_exp[0] = 40'd574448099309;
    stub_exp[1] = 40'd475678957617;
    stub_exp[2] = 40'd0;
    stub_exp[3] = 40'd0;
    stub_exp[4] = 40'd574448099310;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_cmd", command_in, 0);
    chk("rst_a", a_out, 0);

    run(X0, Z0);
    chk("lit_k2", k2_out, 40'd194023909472);
    chk("lit_k3", k3_out, 40'd449729436454);

    // start held high: one rising edge -> one run
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      start = (i < 30);
      if (done) pulses++;
    end
    chk("held_start_done_pulses", pulses, 1);

    run(X0, Z0);
    chk("rerun_k3", k3_out, 40'd449729436454);

    // reduction corners through stubbed readback
    stub_en = 1'b1;
    run(40'd5, 40'd7);
    stub_en = 1'b0;
    chk("red_pm1_pm1", a_out, 40'd574448099309);
    chk("red_max_max", c_out, 40'd475678957617);
    chk("red_zero", k1_out, 40'd0);
    chk("red_p_zero", k2_out, 40'd0);
    chk("red_p_pm1", k3_out, 40'd574448099310);

    // reset in cycle 8 of a run
    @(posedge clk); #1;
    x_in = 40'd1234567; z_in = 40'd7654321; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ins", ins_in, 0);
    chk("midrst_get", get_output, 0);
    chk("midrst_cmd", command_in, 0);
    chk("midrst_k3", k3_out, 0);

    run(X0, Z0);
    chk("after_rst_k2", k2_out, 40'd194023909472);
    run(40'd1099511627775, 40'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
